// File: rtl/boxhead_pkg.sv
// boxhead_pkg: shared FSM state, point type and spawn coordinate table for boxhead enemy spawning
package boxhead_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ISSUE, GAP} spawn_state_t;
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
  } point_t;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  // Four corners, inset 16 px from the screen edges
  localparam point_t SPAWN_TABLE [4] = '{
    '{x: 9'd16, y: 9'd16},
    '{x: 9'(SCREEN_W - 16), y: 9'd16},
    '{x: 9'd16, y: 9'(SCREEN_H - 16)},
    '{x: 9'(SCREEN_W - 16), y: 9'(SCREEN_H - 16)}
  };
  function automatic logic [9:0] manhattan(input point_t p, input logic [8:0] px, input logic [8:0] py);
    return 10'(p.x > px ? p.x - px : px - p.x) + 10'(p.y > py ? p.y - py : py - p.y);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the last grant
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] grant_o,
  output logic         any_req_o
);
  always_comb begin
    grant_o = last_i;
    for (int k = N; k >= 1; k--)
      if (req_i[(int'(last_i) + k) % N]) grant_o = W'((int'(last_i) + k) % N);
  end
  assign any_req_o = |req_i;
endmodule

// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: death/respawn timers and gap-paced round-robin spawn issue over valid/ready.
// Define SPAWN_AVOID_PLAYER_EN to pick the spawn corner farthest from the player instead of LFSR.
module enemy_spawn_scheduler
  import boxhead_pkg::*;
#(
  parameter int ENEMY_NUM        = 4,
  parameter int RESPAWN_FRAMES   = 120,
  parameter int SPAWN_GAP_FRAMES = 30,
  parameter int CNT_W            = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 game_enable,
  input  logic [ENEMY_NUM-1:0] Enemy_Alive,
  input  logic [8:0]           Player_X,
  input  logic [8:0]           Player_Y,
  output logic                 Spawn_Valid,
  output logic [ENEMY_NUM-1:0] Spawn_Sel,
  output logic [8:0]           Spawn_X,
  output logic [8:0]           Spawn_Y,
  input  logic                 Spawn_Ready,
  output logic [7:0]           Kill_Count
);
  localparam int PW = (ENEMY_NUM > 1) ? $clog2(ENEMY_NUM) : 1;
  spawn_state_t         state_q;
  logic [2:0]           fs_q;
  logic [ENEMY_NUM-1:0] alive_q, pend_q, pend_d, death;
  logic [CNT_W-1:0]     cnt_q [ENEMY_NUM];
  logic [CNT_W-1:0]     cnt_d [ENEMY_NUM];
  logic [CNT_W-1:0]     gap_q;
  logic [PW-1:0]        rr_q, grant;
  logic [7:0]           lfsr_q, kill_q, kill_d;
  logic [8:0]           kill_sum, x_q, y_q;
  logic [ENEMY_NUM-1:0] sel_q;
  logic                 valid_q, any_req, run, hs;
  point_t               pick;
  assign run   = fs_q[1] & ~fs_q[2] & game_enable;
  assign death = alive_q & ~Enemy_Alive;
  assign hs    = (state_q == ISSUE) & Spawn_Ready;
  rr_arbiter #(.N(ENEMY_NUM), .W(PW)) u_arb (
    .req_i(pend_q), .last_i(rr_q), .grant_o(grant), .any_req_o(any_req)
  );
`ifdef SPAWN_AVOID_PLAYER_EN
  always_comb begin
    pick = SPAWN_TABLE[0];
    for (int k = 1; k < 4; k++)
      if (manhattan(SPAWN_TABLE[k], Player_X, Player_Y) > manhattan(pick, Player_X, Player_Y)) pick = SPAWN_TABLE[k];
  end
`else
  logic unused_player;
  assign unused_player = ^{Player_X, Player_Y};
  assign pick = SPAWN_TABLE[lfsr_q[1:0]];
`endif
  // A death load overrides both the tick decrement and any pending set
  always_comb begin
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    kill_sum = {1'b0, kill_q};
    if (hs) pend_d[rr_q] = 1'b0;
    for (int i = 0; i < ENEMY_NUM; i++) begin
      if (death[i]) begin
        cnt_d[i]  = CNT_W'(RESPAWN_FRAMES);
        pend_d[i] = 1'b0;
        kill_sum  = kill_sum + 9'd1;
      end else if (run && cnt_q[i] != '0) begin
        cnt_d[i]  = cnt_q[i] - CNT_W'(1);
        pend_d[i] = pend_d[i] | (cnt_q[i] == CNT_W'(1));
      end
    end
    kill_d = kill_sum[8] ? 8'hFF : kill_sum[7:0];
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      fs_q    <= '0;
      alive_q <= '0;
      cnt_q   <= '{default: '0};
      pend_q  <= '1;
      gap_q   <= '0;
      rr_q    <= PW'(ENEMY_NUM - 1);
      lfsr_q  <= 8'hA5;
      kill_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      fs_q    <= {fs_q[1:0], frame_clk};
      alive_q <= Enemy_Alive;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      kill_q  <= kill_d;
      lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      case (state_q)
        IDLE: if (game_enable && any_req && gap_q == '0) state_q <= GRANT;
        GRANT:
          if (any_req) begin
            state_q <= ISSUE;
            valid_q <= 1'b1;
            sel_q   <= ENEMY_NUM'(1) << grant;
            rr_q    <= grant;
            x_q     <= pick.x;
            y_q     <= pick.y;
          end else state_q <= IDLE;
        ISSUE:
          if (Spawn_Ready) begin
            state_q <= GAP;
            valid_q <= 1'b0;
            sel_q   <= '0;
            gap_q   <= CNT_W'(SPAWN_GAP_FRAMES);
          end
        default:
          if (gap_q == '0) state_q <= IDLE;
          else if (run) gap_q <= gap_q - CNT_W'(1);
      endcase
    end
  end
  assign Spawn_Valid = valid_q;
  assign Spawn_Sel   = sel_q;
  assign Spawn_X     = x_q;
  assign Spawn_Y     = y_q;
  assign Kill_Count  = kill_q;
endmodule
